// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Shared system bus arbiter. Grants at most one of NUM_MST masters through a
//   registered one-hot grant vector, using round-robin or fixed-priority
//   selection. An optional hold limit (MAX_HOLD) forces a long-running owner
//   off the bus unless that owner asserts its lock bit.
//
// Parameters
//   NUM_MST   number of masters (2..16)
//   RR_MODE   1 = round-robin, 0 = fixed priority (index 0 highest)
//   MAX_HOLD  max consecutive grant cycles per tenure, 0 = unlimited
//   OWNER_W   width of the owner index (derived, not overridable)
//
// Ports
//   clk        bus clock, rising-edge active
//   rest       asynchronous active-low reset
//   req        per-master request lines
//   lock       per-master lock, honoured only for the current owner
//   grnt       registered grant, one-hot or all-zero
//   owner      index of the current owner (valid while owner_vld is high)
//   owner_vld  a grant is active (OR of grnt)
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NUM_MST  = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  localparam int OWNER_W = (NUM_MST > 2) ? $clog2(NUM_MST) : 1
) (
  input  logic               clk,
  input  logic               rest,
  input  logic [NUM_MST-1:0] req,
  input  logic [NUM_MST-1:0] lock,
  output logic [NUM_MST-1:0] grnt,
  output logic [OWNER_W-1:0] owner,
  output logic               owner_vld
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One extra bit so that start + offset never overflows before the wrap.
  localparam int CW = OWNER_W + 1;
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [15:0]      HOLD_LAST = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MST - 1);

  state_t               state_r, state_s;
  logic [NUM_MST-1:0]   grnt_r, grnt_s;
  logic [OWNER_W-1:0]   owner_r, owner_s;
  logic                 vld_r, vld_s;
  logic [OWNER_W-1:0]   last_r, last_s;
  logic [15:0]          hold_cnt_r, hold_cnt_s;

  logic [OWNER_W-1:0]   start_s;
  logic [NUM_MST-1:0]   owner_1h_s;
  logic [NUM_MST-1:0]   others_s;
  logic                 own_req_s;
  logic                 own_lock_s;
  logic                 keep_s;
  logic [OWNER_W:0]     pick_all_s;
  logic [OWNER_W:0]     pick_oth_s;
  logic                 do_grant_s;
  logic                 go_idle_s;
  logic                 hold_inc_s;
  logic [OWNER_W-1:0]   win_s;

  // Circular search over cand starting at index start; returns {found, index}.
  function automatic logic [OWNER_W:0] pick(input logic [NUM_MST-1:0] cand,
                                            input logic [OWNER_W-1:0] start);
    logic               found;
    logic [OWNER_W-1:0] win;
    logic [CW-1:0]      idx;
    found = 1'b0;
    win   = start;
    for (int off = 0; off < NUM_MST; off++) begin
      idx = {1'b0, start} + CW'(off);
      if (idx >= CW'(NUM_MST)) begin
        idx = idx - CW'(NUM_MST);
      end else begin
        idx = idx;
      end
      if (!found && cand[idx[OWNER_W-1:0]]) begin
        found = 1'b1;
        win   = idx[OWNER_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Search start point: one past the previous owner in round-robin, 0 otherwise.
  always_comb begin
    start_s = {OWNER_W{1'b0}};
    if (RR_MODE != 0) begin
      if (last_r == LAST_IDX) begin
        start_s = {OWNER_W{1'b0}};
      end else begin
        start_s = last_r + OWNER_W'(1'b1);
      end
    end else begin
      start_s = {OWNER_W{1'b0}};
    end
  end

  // Owner-relative views of the request/lock lines and the keep decision.
  always_comb begin
    owner_1h_s = NUM_MST'(1'b1) << owner_r;
    others_s   = req & ~owner_1h_s;
    own_req_s  = req[owner_r];
    own_lock_s = lock[owner_r];
    // Past the limit without lock counts as expired too, so dropping lock
    // late in a long locked tenure still hands the bus over at once.
    keep_s     = own_req_s && (!HOLD_EN || (hold_cnt_r < HOLD_LAST) || own_lock_s);
    pick_all_s = pick(req, start_s);
    // On expiry the owner is excluded; it is only re-granted if alone.
    pick_oth_s = pick(others_s, start_s);
  end

  // Next-state decision: grant, go idle, or keep the owner and count.
  always_comb begin
    do_grant_s = 1'b0;
    go_idle_s  = 1'b0;
    hold_inc_s = 1'b0;
    win_s      = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_all_s[OWNER_W]) begin
          do_grant_s = 1'b1;
          win_s      = pick_all_s[OWNER_W-1:0];
        end else begin
          go_idle_s  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!own_req_s) begin
          if (pick_all_s[OWNER_W]) begin
            do_grant_s = 1'b1;
            win_s      = pick_all_s[OWNER_W-1:0];
          end else begin
            go_idle_s  = 1'b1;
          end
        end else if (keep_s) begin
          hold_inc_s = 1'b1;
        end else if (pick_oth_s[OWNER_W]) begin
          do_grant_s = 1'b1;
          win_s      = pick_oth_s[OWNER_W-1:0];
        end else begin
          do_grant_s = 1'b1;
          win_s      = owner_r;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Register next values derived from the decision above.
  always_comb begin
    state_s    = state_r;
    grnt_s     = grnt_r;
    owner_s    = owner_r;
    vld_s      = vld_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    if (do_grant_s) begin
      state_s    = ST_BUSY;
      grnt_s     = NUM_MST'(1'b1) << win_s;
      owner_s    = win_s;
      vld_s      = 1'b1;
      last_s     = win_s;
      hold_cnt_s = 16'd0;
    end else if (go_idle_s) begin
      state_s    = ST_IDLE;
      grnt_s     = {NUM_MST{1'b0}};
      vld_s      = 1'b0;
    end else if (hold_inc_s) begin
      if (hold_cnt_r != 16'hFFFF) begin
        hold_cnt_s = hold_cnt_r + 16'd1;
      end else begin
        hold_cnt_s = hold_cnt_r;
      end
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_r    <= ST_IDLE;
      grnt_r     <= {NUM_MST{1'b0}};
      owner_r    <= {OWNER_W{1'b0}};
      vld_r      <= 1'b0;
      last_r     <= {OWNER_W{1'b0}};
      hold_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_s;
      grnt_r     <= grnt_s;
      owner_r    <= owner_s;
      vld_r      <= vld_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  assign grnt      = grnt_r;
  assign owner     = owner_r;
  assign owner_vld = vld_r;

  bus_arbiter_rr_chk #(
    .NUM_MST (NUM_MST),
    .OWNER_W (OWNER_W)
  ) u_chk (
    .clk       (clk),
    .rest      (rest),
    .grnt      (grnt_r),
    .owner     (owner_r),
    .owner_vld (vld_r)
  );

endmodule

// -----------------------------------------------------------------------------
// bus_arbiter_rr_chk
//   Structural properties of the arbiter outputs: grant is one-hot or zero,
//   owner_vld mirrors the grant, and the granted bit matches owner.
// Ports
//   clk, rest          clock and active-low reset of the arbiter
//   grnt, owner, owner_vld  arbiter outputs under observation
// -----------------------------------------------------------------------------
module bus_arbiter_rr_chk #(
  parameter int NUM_MST = 4,
  parameter int OWNER_W = 2
) (
  input logic               clk,
  input logic               rest,
  input logic [NUM_MST-1:0] grnt,
  input logic [OWNER_W-1:0] owner,
  input logic               owner_vld
);

  a_onehot: assert property (@(posedge clk) disable iff (!rest) $onehot0(grnt));
  a_vld:    assert property (@(posedge clk) disable iff (!rest) owner_vld == (|grnt));
  a_owner:  assert property (@(posedge clk) disable iff (!rest) owner_vld |-> grnt[owner]);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic       clk;
  logic       rest;
  logic [3:0] req;
  logic [3:0] lock;

  logic [3:0] grnt_rr, grnt_fp, grnt_rr0;
  logic [1:0] owner_rr, owner_fp, owner_rr0;
  logic       vld_rr, vld_fp, vld_rr0;

  logic [3:0] g_s [3];
  logic [1:0] o_s [3];
  logic       v_s [3];

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model state: one entry per instance
  int p_rr  [3] = '{1, 0, 1};
  int p_max [3] = '{4, 4, 0};
  bit m_busy  [3];
  int m_owner [3];
  int m_last  [3];
  int m_hold  [3];

  bus_arbiter_rr #(.NUM_MST(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rest(rest), .req(req), .lock(lock),
    .grnt(grnt_rr), .owner(owner_rr), .owner_vld(vld_rr));

  bus_arbiter_rr #(.NUM_MST(4), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .rest(rest), .req(req), .lock(lock),
    .grnt(grnt_fp), .owner(owner_fp), .owner_vld(vld_fp));

  bus_arbiter_rr #(.NUM_MST(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr0 (
    .clk(clk), .rest(rest), .req(req), .lock(lock),
    .grnt(grnt_rr0), .owner(owner_rr0), .owner_vld(vld_rr0));

  assign g_s[0] = grnt_rr;  assign o_s[0] = owner_rr;  assign v_s[0] = vld_rr;
  assign g_s[1] = grnt_fp;  assign o_s[1] = owner_fp;  assign v_s[1] = vld_fp;
  assign g_s[2] = grnt_rr0; assign o_s[2] = owner_rr0; assign v_s[2] = vld_rr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner among cand for instance k, or -1 when nobody requests
  function automatic int arb(int k, logic [3:0] cand);
    if (p_rr[k] != 0) begin
      for (int off = 1; off <= 4; off++) begin
        int idx;
        idx = (m_last[k] + off) % 4;
        if (cand[idx]) return idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cand[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_g(int k);
    logic [3:0] one;
    one = 4'b0001;
    return m_busy[k] ? (one << m_owner[k]) : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0; m_owner[k] = 0; m_last[k] = 0; m_hold[k] = 0;
    end
  endtask

  task automatic model_grant(int k, int w);
    m_busy[k] = 1'b1; m_owner[k] = w; m_last[k] = w; m_hold[k] = 0;
  endtask

  task automatic model_step(logic [3:0] r, logic [3:0] l);
    for (int k = 0; k < 3; k++) begin
      int w;
      logic [3:0] others;
      if (!m_busy[k]) begin
        w = arb(k, r);
        if (w >= 0) model_grant(k, w);
      end else if (!r[m_owner[k]]) begin
        w = arb(k, r);
        if (w >= 0) model_grant(k, w);
        else m_busy[k] = 1'b0;
      end else if (p_max[k] == 0 || m_hold[k] < p_max[k] - 1 || l[m_owner[k]]) begin
        if (m_hold[k] < 65535) m_hold[k] = m_hold[k] + 1;
      end else begin
        others = r;
        others[m_owner[k]] = 1'b0;
        w = (others != 4'b0000) ? arb(k, others) : m_owner[k];
        model_grant(k, w);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, lock);
    #1;
  endtask

  task automatic apply_reset();
    rest = 1'b0; req = 4'b0000; lock = 4'b0000;
    #2;
    model_reset();
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_reset();
    rest = 1'b1; req = 4'b0000; lock = 4'b0000;
    #1;
    rest = 1'b0;
    #2;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (g_s[k] !== 4'b0000 || v_s[k] !== 1'b0 || o_s[k] !== 2'd0)
        $display("FAIL reset inst=%0d grnt=%b vld=%b owner=%0d required 0/0/0", k, g_s[k], v_s[k], o_s[k]);
      else pass_cnt++;
    end
    req = 4'b1111;
    @(posedge clk); #1;
    total_cnt++;
    if (grnt_rr !== 4'b0000) $display("FAIL reset_hold grnt=%b required 0000", grnt_rr);
    else pass_cnt++;
    req = 4'b0000;
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (grnt_rr !== 4'b0100 || owner_rr !== 2'd2 || vld_rr !== 1'b1 ||
          grnt_fp !== 4'b0100 || owner_fp !== 2'd2)
        $display("FAIL single cyc=%0d rr=%b/%0d/%b fp=%b/%0d required 0100/2/1", i,
                 grnt_rr, owner_rr, vld_rr, grnt_fp, owner_fp);
      else pass_cnt++;
    end
  endtask

  task automatic test_rotation();
    int order [5] = '{1, 2, 3, 0, 1};
    logic [3:0] one;
    one = 4'b0001;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (grnt_rr !== (one << order[i]) || owner_rr !== 2'(order[i]) || vld_rr !== 1'b1)
        $display("FAIL rotation step=%0d grnt=%b owner=%0d required owner %0d", i, grnt_rr, owner_rr, order[i]);
      else pass_cnt++;
      req = 4'b1111 & ~(one << order[i]);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] reqs [4] = '{4'b1010, 4'b1000, 4'b1010, 4'b0010};
    logic [3:0] exps [4] = '{4'b0010, 4'b1000, 4'b1000, 4'b0010};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      tick();
      total_cnt++;
      if (grnt_fp !== exps[i])
        $display("FAIL fixed_order step=%0d grnt=%b required %b", i, grnt_fp, exps[i]);
      else pass_cnt++;
    end
    apply_reset();
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (grnt_fp !== 4'b0010)
        $display("FAIL fixed_1_over_2 cyc=%0d grnt=%b required 0010", i, grnt_fp);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] e_rr, e_fp;
    apply_reset();
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      tick();
      e_rr = (((i / 4) % 2) == 0) ? 4'b0010 : 4'b0001;
      e_fp = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      total_cnt++;
      if (grnt_rr !== e_rr || grnt_fp !== e_fp || grnt_rr0 !== 4'b0010)
        $display("FAIL timeout cyc=%0d rr=%b fp=%b nolimit=%b required %b %b 0010",
                 i, grnt_rr, grnt_fp, grnt_rr0, e_rr, e_fp);
      else pass_cnt++;
    end
    req = 4'b0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (grnt_rr !== 4'b0001 || grnt_fp !== 4'b0001)
        $display("FAIL timeout_alone cyc=%0d rr=%b fp=%b required 0001", i, grnt_rr, grnt_fp);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock();
    apply_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (grnt_rr !== 4'b0001 || grnt_fp !== 4'b0001)
        $display("FAIL lock_hold cyc=%0d rr=%b fp=%b required 0001", i, grnt_rr, grnt_fp);
      else pass_cnt++;
    end
    lock = 4'b0000;
    tick();
    total_cnt++;
    if (grnt_rr !== 4'b0010 || grnt_fp !== 4'b0010 || grnt_rr0 !== 4'b0001)
      $display("FAIL lock_drop rr=%b fp=%b nolimit=%b required 0010 0010 0001", grnt_rr, grnt_fp, grnt_rr0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b1000;
    tick();
    total_cnt++;
    if (grnt_rr !== 4'b1000) $display("FAIL midreset_pre grnt=%b required 1000", grnt_rr);
    else pass_cnt++;
    #2;
    rest = 1'b0;
    #1;
    total_cnt++;
    if (grnt_rr !== 4'b0000 || vld_rr !== 1'b0 || grnt_fp !== 4'b0000)
      $display("FAIL midreset_async rr=%b vld=%b fp=%b required 0000 0 0000", grnt_rr, vld_rr, grnt_fp);
    else pass_cnt++;
    model_reset();
    req = 4'b1001;
    @(negedge clk);
    rest = 1'b1;
    tick();
    total_cnt++;
    if (grnt_rr !== 4'b1000 || grnt_fp !== 4'b0001)
      $display("FAIL midreset_after rr=%b fp=%b required 1000 0001", grnt_rr, grnt_fp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      lock = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tick();
      for (int k = 0; k < 3; k++) begin
        total_cnt++;
        if (g_s[k] !== exp_g(k) || v_s[k] !== m_busy[k] ||
            (m_busy[k] && o_s[k] !== 2'(m_owner[k])))
          $display("FAIL rand_model inst=%0d cyc=%0d grnt=%b exp=%b vld=%b exp=%b owner=%0d exp=%0d",
                   k, c, g_s[k], exp_g(k), v_s[k], m_busy[k], o_s[k], m_owner[k]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_fixed_priority();
    test_timeout();
    test_lock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
